// File: rtl/regsrx8_pkg.sv
// Shared definitions for the RegSRx8 AXI4-Lite register slice.
// Holds the word-index map of the 16-entry register window, slice sizing,
// the AXI response encoding and the byte-lane merge helper.
package regsrx8_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned SR_DEPTH = 8;
  localparam int unsigned DATA_W   = 32;

  // Word indices (byte address bits [5:2]).
  localparam logic [3:0] ADDR_REG0     = 4'd0;
  localparam logic [3:0] ADDR_REG1     = 4'd1;
  localparam logic [3:0] ADDR_REG2     = 4'd2;
  localparam logic [3:0] ADDR_REG3     = 4'd3;
  localparam logic [3:0] ADDR_TAP_BASE = 4'd4;
  localparam logic [3:0] ADDR_TAP_LAST = 4'd11;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  // Replace only the byte lanes enabled by strb.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regsrx8_axil_slave_if.sv
// AXI4-Lite bus bundle for the S00_AXI port of RegSRx8.
// slave modport: the register slice; master modport: the bus driver.
// Signals: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
// R (rdata/rresp/rvalid/rready).
interface regsrx8_axil_slave_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/regsrx8_shift_chain.sv
// Eight-stage (DEPTH) register shift chain.
// Ports: clk, rst_n (sync active-low), shift_en (advance one stage),
//        din (value entering stage 0), taps (all stage outputs, taps[0]=newest).
module regsrx8_shift_chain #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        shift_en,
  input  logic [WIDTH-1:0]            din,
  output logic [DEPTH-1:0][WIDTH-1:0] taps
);

  logic [DEPTH-1:0][WIDTH-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d[0] = din;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        taps_d[k] = taps_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) taps_q <= '0;
    else        taps_q <= taps_d;
  end

  assign taps = taps_q;

endmodule

// File: rtl/regsrx8_axil_slave.sv
// RegSRx8 S00_AXI register slice: four R/W registers at 0x00-0x0C and an
// eight-stage shift chain fed by writes to REG0, taps readable at 0x10-0x2C.
// Ports: s00_axi_aclk (clock), s00_axi_aresetn (sync active-low reset),
//        s00_axi (AXI4-Lite slave bundle), sr_tap (chain taps, [0]=newest),
//        sr_shift (one-cycle pulse following each chain advance).
module regsrx8_axil_slave
  import regsrx8_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                                     s00_axi_aclk,
  input  logic                                     s00_axi_aresetn,
  regsrx8_axil_slave_if.slave                      s00_axi,
  output logic [SR_DEPTH-1:0][C_S_AXI_DATA_WIDTH-1:0] sr_tap,
  output logic                                     sr_shift
);

  typedef enum logic { WR_IDLE, WR_RESP } wr_state_e;
  typedef enum logic { RD_IDLE, RD_RESP } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  axi_resp_t bresp_q, bresp_d;
  axi_resp_t rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_q [NUM_REGS];
  logic [C_S_AXI_DATA_WIDTH-1:0] reg_d [NUM_REGS];
  logic sr_shift_q, sr_shift_d;

  logic [3:0] wr_idx, rd_idx;
  logic [2:0] tap_sel;
  logic       wr_fire, rd_fire, wr_in_regs, shift_en;
  logic [C_S_AXI_DATA_WIDTH-1:0] merged;
  logic [SR_DEPTH-1:0][C_S_AXI_DATA_WIDTH-1:0] taps;

  logic unused_bits;
  assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  assign wr_idx  = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign tap_sel = 3'(rd_idx - ADDR_TAP_BASE);

  // Ready is combinational on valid so a write/read can complete every second
  // cycle; gating with reset keeps ready low while reset is held.
  assign wr_fire = s00_axi.awvalid && s00_axi.wvalid &&
                   (wr_state_q == WR_IDLE) && s00_axi_aresetn;
  assign rd_fire = s00_axi.arvalid && (rd_state_q == RD_IDLE) && s00_axi_aresetn;

  assign wr_in_regs = (wr_idx <= ADDR_REG3);
  assign merged     = merge_bytes(reg_q[wr_idx[1:0]], s00_axi.wdata, s00_axi.wstrb);
  assign shift_en   = wr_fire && (wr_idx == ADDR_REG0);

  // Write channel and register file.
  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    reg_d      = reg_q;
    sr_shift_d = shift_en;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_fire) begin
          wr_state_d = WR_RESP;
          bresp_d    = wr_in_regs ? OKAY : SLVERR;
          if (wr_in_regs) reg_d[wr_idx[1:0]] = merged;
        end
      end
      WR_RESP: begin
        if (s00_axi.bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read channel; data is captured at accept so a same-cycle write is not seen.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_fire) begin
          rd_state_d = RD_RESP;
          rresp_d    = OKAY;
          case (rd_idx)
            ADDR_REG0: rdata_d = reg_q[0];
            ADDR_REG1: rdata_d = reg_q[1];
            ADDR_REG2: rdata_d = reg_q[2];
            ADDR_REG3: rdata_d = reg_q[3];
            default: begin
              if (rd_idx <= ADDR_TAP_LAST) begin
                rdata_d = taps[tap_sel];
              end else begin
                rdata_d = '0;
                rresp_d = SLVERR;
              end
            end
          endcase
        end
      end
      RD_RESP: begin
        if (s00_axi.rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      reg_q      <= '{default: '0};
      sr_shift_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      reg_q      <= reg_d;
      sr_shift_q <= sr_shift_d;
    end
  end

  regsrx8_shift_chain #(
    .DEPTH(SR_DEPTH),
    .WIDTH(C_S_AXI_DATA_WIDTH)
  ) u_chain (
    .clk      (s00_axi_aclk),
    .rst_n    (s00_axi_aresetn),
    .shift_en (shift_en),
    .din      (merged),
    .taps     (taps)
  );

  assign s00_axi.awready = wr_fire;
  assign s00_axi.wready  = wr_fire;
  assign s00_axi.bvalid  = (wr_state_q == WR_RESP);
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.arready = rd_fire;
  assign s00_axi.rvalid  = (rd_state_q == RD_RESP);
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = rresp_q;
  assign sr_tap          = taps;
  assign sr_shift        = sr_shift_q;

endmodule

// File: tb/tb_regsrx8_axil_slave.sv
module tb_regsrx8_axil_slave;
  import regsrx8_pkg::*;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  regsrx8_axil_slave_if bus ();
  logic [SR_DEPTH-1:0][31:0] sr_tap;
  logic sr_shift;

  regsrx8_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(aresetn),
    .s00_axi        (bus),
    .sr_tap         (sr_tap),
    .sr_shift       (sr_shift)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t b_q[$];
  exp_t r_q[$];

  logic [31:0] m_reg[4];
  logic [31:0] m_tap[8];

  int shift_cnt = 0;
  int acc_cnt = 0;
  int split_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (sr_shift) shift_cnt++;
    if (bus.awvalid && bus.wvalid && bus.awready && bus.wready) acc_cnt++;
    if (bus.awready !== bus.wready) split_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    for (int i = 0; i < 8; i++) m_tap[i] = '0;
  endfunction

  function automatic logic [1:0] model_write(input logic [5:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [3:0] idx;
    logic [31:0] v;
    idx = addr[5:2];
    if (idx > 4'd3) return 2'b10;
    v = m_reg[idx[1:0]];
    for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
    m_reg[idx[1:0]] = v;
    if (idx == 4'd0) begin
      for (int k = 7; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = v;
    end
    return 2'b00;
  endfunction

  function automatic exp_t model_read(input string tag, input logic [5:0] addr);
    exp_t e;
    logic [3:0] idx;
    idx = addr[5:2];
    e.tag = tag;
    e.resp = 2'b00;
    if (idx < 4'd4)       e.data = m_reg[idx[1:0]];
    else if (idx < 4'd12) e.data = m_tap[idx - 4'd4];
    else begin
      e.data = '0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  // Caller is at negedge+1.
  task automatic collect_b();
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (bus.bvalid) break;
      @(negedge clk); #1;
    end
    check("bvalid_timeout", {31'b0, bus.bvalid}, 32'd1);
    if (b_q.size() > 0) begin
      e = b_q.pop_front();
      check({e.tag, "_bresp"}, {30'b0, bus.bresp}, {30'b0, e.resp});
    end
    @(negedge clk);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic collect_r();
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (bus.rvalid) break;
      @(negedge clk); #1;
    end
    check("rvalid_timeout", {31'b0, bus.rvalid}, 32'd1);
    if (r_q.size() > 0) begin
      e = r_q.pop_front();
      check({e.tag, "_rdata"}, bus.rdata, e.data);
      check({e.tag, "_rresp"}, {30'b0, bus.rresp}, {30'b0, e.resp});
    end
    @(negedge clk);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  // Caller is at a negedge.
  task automatic do_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    exp_t e;
    e.tag = tag;
    e.data = '0;
    e.resp = model_write(addr, data, strb);
    b_q.push_back(e);
    bus.awaddr = addr;
    bus.wdata = data;
    bus.wstrb = strb;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.awready && bus.wready) break;
      @(negedge clk); #1;
    end
    check({tag, "_wr_accept"}, {31'b0, bus.awready && bus.wready}, 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    #1;
    collect_b();
  endtask

  task automatic do_read(input string tag, input logic [5:0] addr);
    r_q.push_back(model_read(tag, addr));
    bus.araddr = addr;
    bus.arvalid = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.arready) break;
      @(negedge clk); #1;
    end
    check({tag, "_rd_accept"}, {31'b0, bus.arready}, 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    #1;
    collect_r();
  endtask

  initial begin
    logic [31:0] old3;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    model_reset();

    // Reset state, with valids asserted during reset.
    repeat (3) @(negedge clk);
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    #1;
    check("rst_awready", {31'b0, bus.awready}, 32'd0);
    check("rst_wready", {31'b0, bus.wready}, 32'd0);
    check("rst_arready", {31'b0, bus.arready}, 32'd0);
    check("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    check("rst_resp", {28'b0, bus.bresp, bus.rresp}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_sr_shift", {31'b0, sr_shift}, 32'd0);
    check("rst_tap0", sr_tap[0], 32'd0);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    aresetn = 1'b1;
    @(negedge clk);

    // Basic register writes and readback.
    do_write("w_reg0", 6'h00, 32'h1, 4'hF);
    do_write("w_reg1", 6'h04, 32'h2, 4'hF);
    do_write("w_reg2", 6'h08, 32'h3, 4'hF);
    do_write("w_reg3", 6'h0C, 32'h4, 4'hF);
    do_read("r_reg0", 6'h00);
    do_read("r_reg1", 6'h04);
    do_read("r_reg2", 6'h08);
    do_read("r_reg3", 6'h0C);

    // Nine REG0 writes through the chain.
    shift_cnt = 0;
    for (int i = 0; i < 9; i++) do_write("w_chain", 6'h00, 32'hA0 + 32'(i), 4'hF);
    @(negedge clk); #2;
    check("sr_shift_count", 32'(shift_cnt), 32'd9);
    check("tap0_port", sr_tap[0], 32'hA8);
    check("tap7_port", sr_tap[7], 32'hA1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) do_read("r_tap", 6'(6'h10 + 4 * i));

    // Byte strobes and empty strobe.
    do_write("w_reg1_ff", 6'h04, 32'hFFFF_FFFF, 4'hF);
    do_write("w_reg1_strb", 6'h04, 32'h1234_5678, 4'b0101);
    do_read("r_reg1_strb", 6'h04);
    check("reg1_strb_model", m_reg[1], 32'hFF34_FF78);
    do_write("w_reg2_nostrb", 6'h08, 32'hDEAD_BEEF, 4'h0);
    do_read("r_reg2_nostrb", 6'h08);

    // Writes to taps and unmapped space; unmapped read.
    shift_cnt = 0;
    do_write("w_tap1", 6'h14, 32'h5555_5555, 4'hF);
    do_write("w_unmapped", 6'h30, 32'h6666_6666, 4'hF);
    check("tap1_port_unchanged", sr_tap[1], m_tap[1]);
    check("no_shift_on_slverr", 32'(shift_cnt), 32'd0);
    do_read("r_tap1", 6'h14);
    do_read("r_unmapped", 6'h3C);
    do_read("r_unaligned", 6'h0F);

    // Same-cycle read and write of REG3 returns the old value.
    old3 = m_reg[3];
    r_q.push_back(model_read("rw_same", 6'h0C));
    begin
      exp_t e;
      e.tag = "rw_same_w";
      e.data = '0;
      e.resp = model_write(6'h0C, 32'h7777_0000, 4'hF);
      b_q.push_back(e);
    end
    bus.awaddr = 6'h0C; bus.wdata = 32'h7777_0000; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 6'h0C; bus.arvalid = 1'b1;
    #1;
    check("rw_same_accept", {30'b0, bus.awready, bus.arready}, 32'd3);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    #1;
    check("rw_same_old_value", bus.rdata, old3);
    collect_b();
    collect_r();
    do_read("r_reg3_new", 6'h0C);

    // AW three cycles ahead of W, bready held low for five cycles.
    acc_cnt = 0;
    split_cnt = 0;
    begin
      exp_t e;
      e.tag = "w_aw_early";
      e.data = '0;
      e.resp = model_write(6'h08, 32'hCAFE_F00D, 4'hF);
      b_q.push_back(e);
    end
    bus.awaddr = 6'h08; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("aw_early_no_ready", {30'b0, bus.awready, bus.wready}, 32'd0);
      @(negedge clk);
    end
    bus.wvalid = 1'b1;
    #1;
    check("aw_early_ready_pair", {30'b0, bus.awready, bus.wready}, 32'd3);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("b_held_valid", {31'b0, bus.bvalid}, 32'd1);
      check("b_held_no_ready", {30'b0, bus.awready, bus.wready}, 32'd0);
      @(negedge clk);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    #1;
    collect_b();
    @(negedge clk); #2;
    check("single_accept", 32'(acc_cnt), 32'd1);
    check("ready_never_split", 32'(split_cnt), 32'd0);
    @(negedge clk);
    do_read("r_reg2_late", 6'h08);

    // Reset while a read response is pending.
    bus.araddr = 6'h10; bus.arvalid = 1'b1;
    #1;
    check("mid_rst_arready", {31'b0, bus.arready}, 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    #1;
    check("mid_rst_rvalid_pending", {31'b0, bus.rvalid}, 32'd1);
    aresetn = 1'b0;
    @(negedge clk); #1;
    check("mid_rst_rvalid_dropped", {31'b0, bus.rvalid}, 32'd0);
    for (int i = 0; i < 8; i++) check("mid_rst_tap_zero", sr_tap[i], 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    model_reset();
    @(negedge clk);
    do_read("r_after_rst_reg0", 6'h00);
    do_read("r_after_rst_tap0", 6'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
